win_avg_ctrl: RTL and testbench

//   Sequencer/configurator for the win_avg windowed averager in the DOA PL chain.
//   - Gates the sample stream into win_avg and counts samples per averaging window.
//   - Owns win_avg's win_len and applies a new length only at a window boundary,

---
 rtl/win_avg_ctrl.sv | 143 ++++++++++++++
 tb/tb_win_avg_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_avg_ctrl.sv
// Sequencer/configurator for win_avg: gates samples, counts windows, applies new win_len at window boundaries.
// Latency: s_valid/s_ready/avg_valid are combinational pass-through in RUN; win_done/err_badlen one cycle after the event.
// Backpressure: avg_ready is forwarded to s_ready in RUN; s_ready is held low in IDLE, DRAIN and RELOAD.
module win_avg_ctrl #(
  parameter int WIN_W     = 5,
  parameter int MAX_WIN   = 16,
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_wr,
  input  logic [WIN_W-1:0] cfg_win_len,
  output logic             cfg_busy,
  output logic             err_badlen,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic [WIN_W-1:0] avg_win_len,
  output logic             avg_clr,
  output logic             win_done,
  output logic [CNT_W-1:0] win_cnt
);

  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_RELOAD} state_t;

  state_t           state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [WIN_W-1:0] samp_q, samp_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] pend_len_q, pend_len_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cfg_ok;
  logic hs;
  logic last;
  logic drain_end;

  // Request qualification and window-boundary detection
  always_comb begin
    cfg_ok    = cfg_wr && (cfg_win_len != '0) && (int'(cfg_win_len) <= MAX_WIN);
    hs        = (state_q == ST_RUN) && s_valid && avg_ready;
    last      = hs && (samp_q == (len_q - WIN_W'(1)));
    drain_end = (drain_q == DRN_W'(DRAIN_CYC - 1));
  end

  // All state; reset wins over everything, including a window in progress
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drain_q    <= '0;
      samp_q     <= '0;
      len_q      <= WIN_W'(1);
      pend_len_q <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      samp_q     <= samp_d;
      len_q      <= len_d;
      pend_len_q <= pend_len_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: leave RUN only on a window boundary; pending reloads take priority over enable
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q)      state_d = ST_RELOAD;
        else if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last && (pend_q || !enable)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_end) begin
          if (pend_q)       state_d = ST_RELOAD;
          else if (!enable) state_d = ST_IDLE;
          else              state_d = ST_RUN;
        end
      end
      ST_RELOAD: begin
        state_d = enable ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: sample/window counters, drain timer, pending length register
  always_comb begin
    samp_d     = samp_q;
    cnt_d      = cnt_q;
    done_d     = last;
    err_d      = cfg_wr && !cfg_ok;
    drain_d    = (state_q == ST_DRAIN) ? (drain_q + DRN_W'(1)) : '0;
    len_d      = len_q;
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    if (last) begin
      samp_d = '0;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (hs) begin
      samp_d = samp_q + WIN_W'(1);
    end
    if (state_q == ST_RELOAD) begin
      len_d  = pend_len_q;
      pend_d = 1'b0;
    end
    // A write in the reload cycle itself becomes the next pending value
    if (cfg_ok) begin
      pend_d     = 1'b1;
      pend_len_d = cfg_win_len;
    end
  end

  // Outputs: stream gating is combinational from state, pulses come from registers
  always_comb begin
    s_ready     = (state_q == ST_RUN) && avg_ready;
    avg_valid   = (state_q == ST_RUN) && s_valid;
    avg_clr     = (state_q == ST_RELOAD);
    cfg_busy    = pend_q;
    err_badlen  = err_q;
    avg_win_len = len_q;
    win_done    = done_q;
    win_cnt     = cnt_q;
  end

endmodule

// File: tb/tb_win_avg_ctrl.sv
// Self-checking bench for win_avg_ctrl: directed scenarios plus randomized streams.
// Latency: expectations are one cycle behind handshakes for win_done/win_cnt.
// Backpressure: avg_ready driven constant, toggling or random per scenario.
module tb_win_avg_ctrl;

  logic        aclk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_wr;
  logic [4:0]  cfg_win_len;
  logic        cfg_busy;
  logic        err_badlen;
  logic        s_valid;
  logic        s_ready;
  logic        avg_valid;
  logic        avg_ready;
  logic [4:0]  avg_win_len;
  logic        avg_clr;
  logic        win_done;
  logic [15:0] win_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: current window length, handshakes in the open window, completed windows
  int cur_len;
  int in_win;
  int exp_cnt;

  always #5 aclk = ~aclk;

  win_avg_ctrl #(.WIN_W(5), .MAX_WIN(16), .DRAIN_CYC(4), .CNT_W(16)) dut (
    .aclk        (aclk),
    .rst         (rst),
    .enable      (enable),
    .cfg_wr      (cfg_wr),
    .cfg_win_len (cfg_win_len),
    .cfg_busy    (cfg_busy),
    .err_badlen  (err_badlen),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .avg_valid   (avg_valid),
    .avg_ready   (avg_ready),
    .avg_win_len (avg_win_len),
    .avg_clr     (avg_clr),
    .win_done    (win_done),
    .win_cnt     (win_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge aclk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  // Drive samples in RUN until nhs handshakes; enable drops once drop_at handshakes are done.
  // mode 0: full throughput, 1: avg_ready toggles 1010.., 2: random valid/ready
  task automatic stream(input int nhs, input int drop_at, input int mode);
    int done_hs = 0;
    int budget  = nhs * 40 + 50;
    bit tog     = 1'b0;
    bit hs;
    bit exp_done;
    while (done_hs < nhs && budget > 0) begin
      enable = (done_hs < drop_at);
      case (mode)
        0: begin s_valid = 1'b1; avg_ready = 1'b1; end
        1: begin s_valid = 1'b1; avg_ready = ~tog; tog = ~tog; end
        default: begin
          s_valid   = 1'($urandom_range(0, 1));
          avg_ready = 1'($urandom_range(0, 1));
        end
      endcase
      settle;
      chk("pass_ready", s_ready, avg_ready);
      chk("pass_valid", avg_valid, s_valid);
      hs = s_valid & avg_ready;
      cyc;
      exp_done = 1'b0;
      if (hs) begin
        done_hs++;
        in_win++;
        if (in_win == cur_len) begin
          in_win   = 0;
          exp_cnt++;
          exp_done = 1'b1;
        end
      end
      chk("win_done", win_done, exp_done);
      chk("win_cnt", win_cnt, exp_cnt & 32'hFFFF);
      budget--;
    end
    if (done_hs < nhs) chk("stream_timeout", done_hs, nhs);
    s_valid = 1'b0;
    chk("len_stable", avg_win_len, cur_len);
  endtask

  // Drain must block the stream for exactly four cycles, then go to RELOAD, IDLE or RUN
  task automatic drain(input bit en, input bit to_reload);
    enable    = en;
    s_valid   = 1'b1;
    avg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle;
      chk("drain_ready", s_ready, 0);
      chk("drain_valid", avg_valid, 0);
      cyc;
    end
    settle;
    chk("post_drain_clr", avg_clr, to_reload);
    chk("post_drain_ready", s_ready, en && !to_reload);
    s_valid = 1'b0;
  endtask

  // Legal length written in IDLE with enable low: pending, reload with clear, back to IDLE
  task automatic configure(input int len);
    cfg_wr      = 1'b1;
    cfg_win_len = len[4:0];
    cyc;
    cfg_wr = 1'b0;
    chk("cfg_busy_set", cfg_busy, 1);
    cyc;
    settle;
    chk("reload_clr", avg_clr, 1);
    cyc;
    chk("len_applied", avg_win_len, len);
    chk("busy_clear", cfg_busy, 0);
    settle;
    chk("clr_one_cycle", avg_clr, 0);
    cur_len = len;
    in_win  = 0;
  endtask

  initial begin
    int rl;
    int nw;
    rst         = 1'b1;
    enable      = 1'b0;
    cfg_wr      = 1'b0;
    cfg_win_len = '0;
    s_valid     = 1'b1;
    avg_ready   = 1'b1;
    cyc;
    cyc;
    settle;
    chk("rst_len", avg_win_len, 1);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_cnt", win_cnt, 0);
    chk("rst_done", win_done, 0);
    chk("rst_err", err_badlen, 0);
    chk("rst_clr", avg_clr, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_valid", avg_valid, 0);
    rst     = 1'b0;
    cur_len = 1;
    in_win  = 0;
    exp_cnt = 0;
    cyc;
    settle;
    chk("idle_hold", s_ready, 0);

    // Length-1 windows at full rate, then stop
    enable = 1'b1;
    cyc;
    stream(6, 5, 0);
    drain(1'b0, 1'b0);

    // Reconfigure to 4 in IDLE, three windows
    configure(4);
    enable = 1'b1;
    cyc;
    stream(12, 11, 0);
    drain(1'b0, 1'b0);

    // Length change requested mid-window: finishes, drains, reloads into RUN
    enable = 1'b1;
    cyc;
    stream(2, 99, 0);
    cfg_wr      = 1'b1;
    cfg_win_len = 5'd8;
    s_valid     = 1'b0;
    cyc;
    cfg_wr = 1'b0;
    chk("mid_busy", cfg_busy, 1);
    chk("mid_no_done", win_done, 0);
    stream(2, 99, 0);
    drain(1'b1, 1'b1);
    cyc;
    cur_len = 8;
    in_win  = 0;
    chk("mid_len", avg_win_len, 8);
    chk("mid_busy_clear", cfg_busy, 0);
    settle;
    chk("mid_run", s_ready, 1);
    stream(16, 15, 2);
    drain(1'b0, 1'b0);

    // Illegal lengths rejected with a one-cycle error pulse
    cfg_wr      = 1'b1;
    cfg_win_len = 5'd0;
    cyc;
    cfg_wr = 1'b0;
    chk("bad0_err", err_badlen, 1);
    chk("bad0_busy", cfg_busy, 0);
    cyc;
    chk("bad0_err_off", err_badlen, 0);
    cfg_wr      = 1'b1;
    cfg_win_len = 5'($urandom_range(17, 31));
    cyc;
    cfg_wr = 1'b0;
    chk("badhi_err", err_badlen, 1);
    chk("badhi_busy", cfg_busy, 0);
    cyc;
    chk("badhi_err_off", err_badlen, 0);
    chk("bad_len_kept", avg_win_len, 8);
    settle;
    chk("bad_no_clr", avg_clr, 0);

    // Latest write wins; a write during RELOAD becomes the next pending length
    cfg_wr      = 1'b1;
    cfg_win_len = 5'd3;
    cyc;
    cfg_win_len = 5'd5;
    cyc;
    cfg_win_len = 5'd4;
    settle;
    chk("ow_clr", avg_clr, 1);
    cyc;
    cfg_wr = 1'b0;
    chk("ow_len", avg_win_len, 5);
    chk("ow_busy", cfg_busy, 1);
    settle;
    chk("ow_idle", avg_clr, 0);
    cyc;
    settle;
    chk("ow_clr2", avg_clr, 1);
    cyc;
    chk("ow_len2", avg_win_len, 4);
    chk("ow_busy2", cfg_busy, 0);
    cur_len = 4;
    in_win  = 0;

    // Toggling ready with enable dropped after the first sample
    enable = 1'b1;
    cyc;
    stream(4, 1, 1);
    drain(1'b0, 1'b0);

    // Reset mid-window with a length pending
    enable = 1'b1;
    cyc;
    stream(2, 99, 0);
    cfg_wr      = 1'b1;
    cfg_win_len = 5'd7;
    s_valid     = 1'b0;
    cyc;
    cfg_wr = 1'b0;
    chk("pre_rst_busy", cfg_busy, 1);
    s_valid = 1'b1;
    rst     = 1'b1;
    cyc;
    rst    = 1'b0;
    enable = 1'b0;
    chk("mrst_done", win_done, 0);
    chk("mrst_cnt", win_cnt, 0);
    chk("mrst_len", avg_win_len, 1);
    chk("mrst_busy", cfg_busy, 0);
    settle;
    chk("mrst_ready", s_ready, 0);
    cyc;
    chk("mrst_no_done", win_done, 0);
    settle;
    chk("mrst_no_reload", avg_clr, 0);
    exp_cnt = 0;
    cur_len = 1;
    in_win  = 0;

    // Random lengths and window counts with random valid/ready
    for (int r = 0; r < 4; r++) begin
      rl = $urandom_range(1, 16);
      nw = $urandom_range(1, 3);
      configure(rl);
      enable = 1'b1;
      cyc;
      stream(rl * nw, rl * nw - 1, 2);
      drain(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
